// File: rtl/comm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | comm_pkg : opcodes, per-opcode byte counts and FSM state type shared by     |
// |            comm_host and the comm responder.                                |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package comm_pkg;

    localparam logic [3:0] COMM_READ_ENABLE_MASK  = 4'h1;
    localparam logic [3:0] COMM_WRITE_ENABLE_MASK = 4'h2;
    localparam logic [3:0] COMM_READ_PIN_MAP      = 4'h3;
    localparam logic [3:0] COMM_WRITE_PIN_MAP     = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_OP  = 3'd1,
        ST_SEND_PAY = 3'd2,
        ST_RECV     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic logic comm_op_known(input logic [3:0] op);
        return (op == COMM_READ_ENABLE_MASK) || (op == COMM_WRITE_ENABLE_MASK) ||
               (op == COMM_READ_PIN_MAP)     || (op == COMM_WRITE_PIN_MAP);
    endfunction

    // Payload bytes sent by the host after the opcode byte.
    function automatic logic [2:0] comm_tx_len(input logic [3:0] op);
        case (op)
            COMM_WRITE_ENABLE_MASK: return 3'd2;
            COMM_WRITE_PIN_MAP:     return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    // Response bytes returned by the responder.
    function automatic logic [2:0] comm_rx_len(input logic [3:0] op);
        case (op)
            COMM_READ_ENABLE_MASK, COMM_WRITE_ENABLE_MASK: return 3'd2;
            COMM_READ_PIN_MAP, COMM_WRITE_PIN_MAP:         return 3'd4;
            default:                                       return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/comm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | comm : serial responder holding the enable mask and pin map registers.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module comm
    import comm_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic tx
);
    state_t      r_state;
    logic [3:0]  r_op;
    logic [2:0]  r_cnt;
    logic [31:0] r_buf;
    logic [15:0] r_enable_mask;
    logic [31:0] r_pin_map;
    logic        r_issued;
    logic        w_rx_ready;
    logic        w_tx_done;
    logic        w_tx_start;
    logic [7:0]  w_rx_data;

    assign w_tx_start = (r_state == ST_SEND_PAY) && !r_issued;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_op          <= '0;
            r_cnt         <= '0;
            r_buf         <= '0;
            r_enable_mask <= '0;
            r_pin_map     <= '0;
            r_issued      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_ready && (w_rx_data[7:4] == 4'h0) && comm_op_known(w_rx_data[3:0])) begin
                        r_op     <= w_rx_data[3:0];
                        r_cnt    <= '0;
                        r_issued <= 1'b0;
                        if (comm_tx_len(w_rx_data[3:0]) == 3'd0) begin
                            r_buf   <= (w_rx_data[3:0] == COMM_READ_PIN_MAP) ? r_pin_map
                                                                             : {16'h0, r_enable_mask};
                            r_state <= ST_SEND_PAY;
                        end else begin
                            r_buf   <= '0;
                            r_state <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (w_rx_ready) begin
                        r_buf[{r_cnt[1:0], 3'b000} +: 8] <= w_rx_data;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt + 3'd1 == comm_tx_len(r_op)) r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Commit the write; the response echoes the stored value.
                    if (r_op == COMM_WRITE_ENABLE_MASK) r_enable_mask <= r_buf[15:0];
                    else                                r_pin_map     <= r_buf;
                    r_cnt   <= '0;
                    r_state <= ST_SEND_PAY;
                end
                ST_SEND_PAY: begin
                    if (!r_issued) begin
                        r_issued <= 1'b1;
                    end else if (w_tx_done) begin
                        r_issued <= 1'b0;
                        r_buf    <= {8'h00, r_buf[31:8]};
                        r_cnt    <= r_cnt + 3'd1;
                        if (r_cnt + 3'd1 == comm_rx_len(r_op)) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (w_rx_data),
        .rx_ready (w_rx_ready)
    );

    uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_ready (w_tx_start),
        .data       (r_buf[7:0]),
        .tx         (tx),
        .tx_done    (w_tx_done)
    );

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx : 8N1 receiver, mid-bit sampling, rx_ready pulse per valid frame.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rx #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready
);
    localparam int c_cnt_w = $clog2(CLK_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLK_PER_BIT / 2);

    logic [1:0]         r_sync;
    logic               r_busy;
    logic               r_ready;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic [3:0]         r_bit;
    logic [c_cnt_w-1:0] r_clk;
    logic               w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_shift <= '0;
            r_data  <= '0;
            r_bit   <= '0;
            r_clk   <= '0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_ready <= 1'b0;
            if (!r_busy) begin
                if (!w_rx) begin
                    r_busy <= 1'b1;
                    r_bit  <= '0;
                    // Start half-way so every later sample lands mid-bit.
                    r_clk  <= c_half;
                end
            end else if (r_clk == c_last) begin
                r_clk <= '0;
                if (r_bit == 4'd0) begin
                    if (w_rx) r_busy <= 1'b0;
                    else      r_bit  <= 4'd1;
                end else if (r_bit == 4'd9) begin
                    r_busy  <= 1'b0;
                    r_ready <= w_rx;
                    r_data  <= r_shift;
                end else begin
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_clk <= r_clk + 1'b1;
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx : 8N1 transmitter, one byte per data_ready pulse, tx_done pulse at  |
// |           the end of the stop bit.                                          |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_ready,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_done
);
    localparam int c_cnt_w = $clog2(CLK_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_PER_BIT - 1);

    logic               r_busy;
    logic               r_tx;
    logic               r_done;
    logic [8:0]         r_shift;
    logic [3:0]         r_bit;
    logic [c_cnt_w-1:0] r_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_shift <= '0;
            r_bit   <= '0;
            r_clk   <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (data_ready) begin
                    r_busy  <= 1'b1;
                    r_tx    <= 1'b0;
                    r_shift <= {1'b1, data};
                    r_bit   <= '0;
                    r_clk   <= '0;
                end
            end else if (r_clk == c_last) begin
                r_clk <= '0;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_tx   <= 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_clk <= r_clk + 1'b1;
            end
        end
    end

    assign tx      = r_tx;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: rtl/comm_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | comm_host : command-to-UART host for the comm responder.                    |
// |             Optional response timeout under COMM_HOST_TIMEOUT_EN.           |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module comm_host
    import comm_pkg::*;
#(
    parameter int CLK_PER_BIT    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        serial_tx,
    input  logic        serial_rx
);
    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [31:0] r_wdata;
    logic        r_bad;
    logic [2:0]  r_tx_left;
    logic [1:0]  r_tx_idx;
    logic        r_tx_issued;
    logic [2:0]  r_rx_count;
    logic [31:0] r_rx_buf;
    logic [31:0] r_rsp_data;
    logic        r_err;

    logic        w_accept, w_sending, w_armed, w_rx_full, w_timeout;
    logic        w_tx_start, w_tx_done, w_rx_ready;
    logic [7:0]  w_tx_byte, w_rx_data;

    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_sending  = (r_state == ST_SEND_OP) || (r_state == ST_SEND_PAY);
    assign w_armed    = w_sending || (r_state == ST_RECV);
    assign w_rx_full  = r_rx_count >= comm_rx_len(r_op);
    assign w_tx_start = w_sending && !r_tx_issued && !r_bad;
    assign w_tx_byte  = (r_state == ST_SEND_OP) ? {4'h0, r_op} : r_wdata[{r_tx_idx, 3'b000} +: 8];

`ifdef COMM_HOST_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_limit = c_to_w'(TIMEOUT_CYCLES);
    logic [c_to_w-1:0] r_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_to <= '0;
        else if (w_accept || w_rx_ready) r_to <= '0;
        else if (w_armed)                r_to <= r_to + 1'b1;
    end

    assign w_timeout = w_armed && (r_to == c_to_limit);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (cmd_valid) w_next = ST_SEND_OP;
            ST_SEND_OP: begin
                if (r_bad || w_timeout)           w_next = ST_DONE;
                else if (r_tx_issued && w_tx_done) w_next = (r_tx_left == 3'd0) ? ST_RECV : ST_SEND_PAY;
            end
            ST_SEND_PAY: begin
                if (w_timeout)                                          w_next = ST_DONE;
                else if (r_tx_issued && w_tx_done && r_tx_left == 3'd1) w_next = ST_RECV;
            end
            ST_RECV:     if (w_timeout || w_rx_full) w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_DONE);
        rsp_err   = (r_state == ST_DONE) && r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_wdata     <= '0;
            r_bad       <= 1'b0;
            r_tx_left   <= '0;
            r_tx_idx    <= '0;
            r_tx_issued <= 1'b0;
            r_rx_count  <= '0;
            r_rx_buf    <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op        <= cmd_op;
                r_wdata     <= cmd_wdata;
                r_bad       <= !comm_op_known(cmd_op);
                r_tx_left   <= comm_tx_len(cmd_op);
                r_tx_idx    <= '0;
                r_tx_issued <= 1'b0;
                r_rx_count  <= '0;
                r_rx_buf    <= '0;
            end else begin
                if (w_tx_start) begin
                    r_tx_issued <= 1'b1;
                end else if (w_sending && r_tx_issued && w_tx_done) begin
                    r_tx_issued <= 1'b0;
                    if (r_state == ST_SEND_PAY) begin
                        r_tx_left <= r_tx_left - 3'd1;
                        r_tx_idx  <= r_tx_idx + 2'd1;
                    end
                end
                // Bytes outside the armed window or beyond the expected count are dropped.
                if (w_rx_ready && w_armed && !w_rx_full) begin
                    r_rx_buf[{r_rx_count[1:0], 3'b000} +: 8] <= w_rx_data;
                    r_rx_count <= r_rx_count + 3'd1;
                end
            end
            if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
                r_rsp_data <= r_rx_buf;
                r_err      <= r_bad || w_timeout;
            end
        end
    end

    assign rsp_data = r_rsp_data;

    uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_ready (w_tx_start),
        .data       (w_tx_byte),
        .tx         (serial_tx),
        .tx_done    (w_tx_done)
    );

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (serial_rx),
        .rx_data  (w_rx_data),
        .rx_ready (w_rx_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_comm_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_comm_host : comm_host wired back-to-back with comm, scoreboard checked.  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_comm_host;
    import comm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_op = 4'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        cmd_ready, rsp_valid, rsp_err, serial_tx, serial_rx, resp_line;
    logic [31:0] rsp_data;
    logic        line_break = 1'b0;

    assign serial_rx = resp_line | line_break;

    comm_host #(.CLK_PER_BIT(16), .TIMEOUT_CYCLES(200)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .serial_tx (serial_tx),
        .serial_rx (serial_rx)
    );

    comm #(.CLK_PER_BIT(16)) u_resp (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (serial_tx),
        .tx    (resp_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   rsp_seen = 0;

    // Monitor: every rsp_valid pulse must match the oldest outstanding expectation.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_seen++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp got data=%h err=%b required no response", rsp_data, rsp_err);
            end else begin
                m_e = exp_q.pop_front();
                if (rsp_data !== m_e.data || rsp_err !== m_e.err) begin
                    n_fail++;
                    $display("FAIL rsp got data=%h err=%b required data=%h err=%b",
                             rsp_data, rsp_err, m_e.data, m_e.err);
                end
                if (m_e.due >= 0) begin
                    n_tests++;
                    if (cyc != m_e.due) begin
                        n_fail++;
                        $display("FAIL rsp_latency got cycle %0d required cycle %0d", cyc, m_e.due);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    // Drive one command; the expected response goes to the scoreboard at acceptance.
    // Timed responses must appear one edge after the accepting edge (two cycles after acceptance).
    task automatic issue(input logic [3:0] op, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input bit timed);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        while (!cmd_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        e.data = exp_d;
        e.err  = exp_e;
        e.due  = timed ? cyc + 1 : -1;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_no_rsp got %0d outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish required finish before 2ms");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        bit low_seen;
        int k;

        repeat (4) @(negedge clk);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_serial_tx", {31'h0, serial_tx}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // Unknown opcode: error response with zero data, line untouched.
        low_seen = 1'b0;
        issue(4'hF, 32'h12345678, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (!serial_tx) low_seen = 1'b1;
            @(negedge clk);
        end
        check("badop_line_idle", {31'h0, low_seen}, 32'h0);
        wait_drain("badop", 100);

`ifdef COMM_HOST_TIMEOUT_EN
        // Silent responder: the read must be abandoned with an error and no data.
        line_break = 1'b1;
        issue(COMM_READ_PIN_MAP, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_drain("timeout", 1000);
        repeat (400) @(negedge clk);

        // Reset in the middle of the payload: no response, line released.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = COMM_WRITE_PIN_MAP;
        cmd_wdata = 32'h0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        while (dut.r_state != ST_SEND_PAY && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_send_pay", {31'h0, (dut.r_state == ST_SEND_PAY)}, 32'h1);
        repeat (10) @(negedge clk);
        check("payload_on_line", {31'h0, serial_tx}, 32'h0);
        k = rsp_seen;
        rst_n = 1'b0;
        #1;
        check("abort_serial_tx", {31'h0, serial_tx}, 32'h1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("abort_no_rsp", rsp_seen - k, 32'h0);
        check("abort_cmd_ready", {31'h0, cmd_ready}, 32'h1);
`else
        issue(COMM_READ_PIN_MAP, 32'h0, 32'h00000000, 1'b0, 1'b0);
        wait_drain("rd_pin0_a", 4000);
        issue(COMM_READ_PIN_MAP, 32'h0, 32'h00000000, 1'b0, 1'b0);
        wait_drain("rd_pin0_b", 4000);

        issue(COMM_WRITE_ENABLE_MASK, 32'h0000abcd, 32'h0000abcd, 1'b0, 1'b0);
        wait_drain("wr_mask", 4000);
        issue(COMM_READ_ENABLE_MASK, 32'h0, 32'h0000abcd, 1'b0, 1'b0);
        wait_drain("rd_mask_a", 4000);

        // A second request while busy must be dropped, not queued.
        issue(COMM_READ_ENABLE_MASK, 32'h0, 32'h0000abcd, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = COMM_WRITE_ENABLE_MASK;
        cmd_wdata = 32'h00001234;
        repeat (5) @(negedge clk);
        check("busy_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        cmd_valid = 1'b0;
        wait_drain("rd_mask_b", 4000);
        repeat (200) @(negedge clk);
        check("busy_no_extra_rsp", {31'h0, (exp_q.size() == 0)}, 32'h1);

        issue(COMM_WRITE_PIN_MAP, 32'h89abcdef, 32'h89abcdef, 1'b0, 1'b0);
        wait_drain("wr_pin_a", 4000);
        issue(COMM_READ_PIN_MAP, 32'h0, 32'h89abcdef, 1'b0, 1'b0);
        wait_drain("rd_pin_a", 4000);
        issue(COMM_WRITE_PIN_MAP, 32'haaff5500, 32'haaff5500, 1'b0, 1'b0);
        wait_drain("wr_pin_b", 4000);
        issue(COMM_READ_PIN_MAP, 32'h0, 32'haaff5500, 1'b0, 1'b0);
        wait_drain("rd_pin_b", 4000);
        issue(COMM_READ_ENABLE_MASK, 32'h0, 32'h0000abcd, 1'b0, 1'b0);
        wait_drain("rd_mask_c", 4000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comm_host.md
COMM_HOST -- requirements
Module: comm_host

Interface
REQ-001 Parameter CLK_PER_BIT, default 16: clock cycles per UART bit, passed to both UART instances.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: idle-line cycles before a response is abandoned (used only when COMM_HOST_TIMEOUT_EN is defined).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request strobe.
REQ-006 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-007 cmd_op  input  4  opcode, sampled on acceptance.
REQ-008 cmd_wdata  input  32  write payload, sampled on acceptance.
REQ-009 rsp_valid  output  1  one-cycle pulse marking a completed transaction.
REQ-010 rsp_data  output  32  assembled response, zero-extended, held until the next rsp_valid.
REQ-011 rsp_err  output  1  qualifies rsp_valid: unknown opcode or timeout.
REQ-012 serial_tx  output  1  UART line to the comm responder; idles high.
REQ-013 serial_rx  input  1  UART line from the comm responder.

Function
REQ-014 Transaction lengths, payload and response both LSB byte first:
- COMM_READ_ENABLE_MASK: tx 0 payload bytes, rx 2 bytes.
- COMM_WRITE_ENABLE_MASK: tx 2 payload bytes, rx 2 bytes.
- COMM_READ_PIN_MAP: tx 0 payload bytes, rx 4 bytes.
- COMM_WRITE_PIN_MAP: tx 4 payload bytes, rx 4 bytes.
REQ-015 The opcode byte on the line is {4'h0, cmd_op}.
REQ-016 The FSM states are IDLE -> SEND_OP -> SEND_PAY (skipped when the payload length is 0) -> RECV -> DONE -> IDLE.
REQ-017 SEND_OP and SEND_PAY: each byte is presented to uart_tx with a one-cycle data_ready pulse; the next byte is issued only after the tx_done pulse of the previous byte.
REQ-018 RX capture is armed from acceptance through RECV; response bytes arriving during SEND_PAY are stored and counted.
REQ-019 Each rx_ready pulse writes rx_data into byte lane rx_count, then increments rx_count.
REQ-020 The FSM enters DONE on the cycle after the final expected byte is stored, provided the last tx_done has also occurred.
REQ-021 DONE lasts exactly one cycle: rsp_valid=1, rsp_err=0.
REQ-022 An unknown cmd_op produces no line activity; rsp_valid=1 and rsp_err=1 two cycles after acceptance, with rsp_data=0.
REQ-023 rx bytes received in IDLE or DONE are discarded, and rx_count is not changed.
REQ-024 Excess rx bytes beyond the expected count are discarded.
REQ-025 cmd_valid while busy is ignored and not queued.
REQ-026 Internal counters wrap at their width; byte indices never exceed 3.

Reset
REQ-027 During reset: state=IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_data=0, serial_tx=1, and all counters are 0.
REQ-028 Reset mid-transaction aborts it with no rsp_valid; a UART frame in flight is truncated and serial_tx returns high within one cycle.

Configuration
REQ-029 When COMM_HOST_TIMEOUT_EN is defined:
- a counter clears on acceptance and on each rx_ready, and increments in SEND_*/RECV;
- when it reaches TIMEOUT_CYCLES the FSM enters DONE with rsp_err=1, and rsp_data holds the bytes received so far.
REQ-030 When COMM_HOST_TIMEOUT_EN is undefined, no timeout counter exists and RECV waits indefinitely.

Structure
REQ-031 The COMM_* opcode constants, the per-opcode tx/rx length table and the FSM state typedef live in comm_pkg, shared with comm.
REQ-032 No new sub-module is added; comm_host instantiates the existing uart_tx and uart_rx with CLK_PER_BIT.

Verification
REQ-033 Bench: comm_host connected back-to-back with comm, CLK_PER_BIT=16.
REQ-034 Out of reset, issue COMM_READ_PIN_MAP twice -> rsp_data=32'h00000000, rsp_err=0, both times.
REQ-035 Issue COMM_WRITE_ENABLE_MASK with cmd_wdata=32'habcd -> rsp_data=32'h0000abcd; then two COMM_READ_ENABLE_MASK -> 32'h0000abcd each.
REQ-036 Issue COMM_WRITE_PIN_MAP with cmd_wdata=32'h89abcdef -> rsp_data=32'h89abcdef; then COMM_READ_PIN_MAP -> 32'h89abcdef; then a write of 32'haaff5500 and a readback -> 32'haaff5500.
REQ-037 Issue cmd_op=4'hF -> rsp_err=1 two cycles after acceptance; serial_tx stays high throughout.
REQ-038 With COMM_HOST_TIMEOUT_EN defined, TIMEOUT_CYCLES=200 and serial_rx tied high, issue COMM_READ_PIN_MAP -> rsp_err=1 and rsp_data=0; then assert rst_n low mid-SEND_PAY -> no rsp_valid, and serial_tx is high within 1 cycle.
